bp_lce_busy_ctrl: RTL and testbench

Parametrised backpressure controller for the LCE: it generates the cache-facing busy signal and tracks outstanding LCE request credits. It generalises single-counter LCE timeout logic to `num_ports_p` cache memory ports, with a separate blocked-cycle counter per port. After a timeout it enters a holdoff window that keeps busy asserted, which guarantees the LCE a free cache port. It sits in the LCE top level, between the request/command engines and the cache request interface.

---
 rtl/bp_lce_busy_ctrl.sv | 115 +++++++++++
 tb/tb_bp_lce_busy_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bp_lce_busy_ctrl.sv
// LCE backpressure controller: per-port blocked-cycle timeouts with a post-timeout
// holdoff window, outstanding request credit tracking, and the cache-facing busy.
module bp_lce_busy_ctrl #(
  parameter int num_ports_p         = 3,
  parameter int timeout_max_limit_p = 4,
  parameter int holdoff_p           = 2,
  parameter int credits_p           = 32,
  localparam int CW = $clog2(credits_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_ports_p-1:0] mem_pkt_v_i,
  input  logic [num_ports_p-1:0] mem_pkt_yumi_i,
  input  logic                   credit_alloc_i,
  input  logic                   credit_return_i,
  input  logic                   cmd_ready_i,
  input  logic                   req_ready_i,
  output logic                   busy_o,
  output logic [num_ports_p-1:0] timeout_o,
  output logic                   holdoff_o,
  output logic [CW-1:0]          credit_count_o,
  output logic                   credits_full_o,
  output logic                   credits_empty_o
);

  localparam int CNT_W = $clog2(timeout_max_limit_p + 1);
  localparam int HO_W  = (holdoff_p > 0) ? $clog2(holdoff_p + 1) : 1;

  if (num_ports_p < 1 || timeout_max_limit_p < 1 || holdoff_p < 0 || credits_p < 1) begin : g_bad_param
    $error("bp_lce_busy_ctrl: parameter below its lower bound");
  end

  typedef enum logic {RUN, HOLDOFF} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_W'(timeout_max_limit_p)) return v;
    return v + 1'b1;
  endfunction

  logic [num_ports_p-1:0] blocked;
  logic [CNT_W-1:0]       cnt [num_ports_p];
  state_e                 state_q, state_d;
  logic [HO_W-1:0]        ho_q, ho_d;
  logic [CW-1:0]          count_q;

  assign blocked = mem_pkt_v_i & ~mem_pkt_yumi_i;

  // Per-port blocked counters; any unblocked cycle restarts the count.
  for (genvar i = 0; i < num_ports_p; i++) begin : g_port
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)         cnt[i] <= '0;
      else if (blocked[i]) cnt[i] <= sat_inc(cnt[i]);
      else                 cnt[i] <= '0;
    end
    assign timeout_o[i] = (cnt[i] == CNT_W'(timeout_max_limit_p));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      ho_q    <= '0;
    end else begin
      state_q <= state_d;
      ho_q    <= ho_d;
    end
  end

  // Holdoff only releases once its minimum window is spent and no port is stuck.
  always_comb begin
    state_d = state_q;
    ho_d    = ho_q;
    case (state_q)
      RUN: begin
        if (|timeout_o) begin
          state_d = HOLDOFF;
          ho_d    = HO_W'(holdoff_p);
        end
      end
      HOLDOFF: begin
        if (ho_q != '0)      ho_d    = ho_q - 1'b1;
        else if (~|blocked)  state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      case ({credit_alloc_i, credit_return_i})
        2'b10:   if (!credits_full_o)  count_q <= count_q + 1'b1;
        2'b01:   if (!credits_empty_o) count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && credit_alloc_i && !credit_return_i && credits_full_o)
      $error("bp_lce_busy_ctrl: credit alloc while full");
    if (!reset_i && credit_return_i && !credit_alloc_i && credits_empty_o)
      $error("bp_lce_busy_ctrl: credit return while empty");
  end
`endif

  assign credit_count_o  = count_q;
  assign credits_full_o  = (count_q == CW'(credits_p));
  assign credits_empty_o = (count_q == '0);
  assign holdoff_o       = (state_q == HOLDOFF);
  assign busy_o          = reset_i | credits_full_o | (|timeout_o) | holdoff_o
                           | ~cmd_ready_i | ~req_ready_i;

endmodule

// File: tb/tb_bp_lce_busy_ctrl.sv
// Directed bench for bp_lce_busy_ctrl with default parameters (3 ports, limit 4,
// holdoff 2, 32 credits); inputs change #1 after the rising edge, outputs sampled there.
module tb_bp_lce_busy_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [2:0] mem_pkt_v_i, mem_pkt_yumi_i;
  logic       credit_alloc_i, credit_return_i, cmd_ready_i, req_ready_i;
  logic       busy_o, holdoff_o, credits_full_o, credits_empty_o;
  logic [2:0] timeout_o;
  logic [5:0] credit_count_o;

  int n_chk  = 0;
  int n_pass = 0;
  int entries;
  logic prev_ho;

  bp_lce_busy_ctrl dut (
    .clk_i(clk), .reset_i(reset_i),
    .mem_pkt_v_i(mem_pkt_v_i), .mem_pkt_yumi_i(mem_pkt_yumi_i),
    .credit_alloc_i(credit_alloc_i), .credit_return_i(credit_return_i),
    .cmd_ready_i(cmd_ready_i), .req_ready_i(req_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o), .holdoff_o(holdoff_o),
    .credit_count_o(credit_count_o), .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; mem_pkt_v_i = '0; mem_pkt_yumi_i = '0;
    credit_alloc_i = 1'b0; credit_return_i = 1'b0;
    cmd_ready_i = 1'b1; req_ready_i = 1'b1;
    step(); step();
    chk("rst_busy", busy_o, 1);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_holdoff", holdoff_o, 0);
    chk("rst_count", credit_count_o, 0);
    chk("rst_empty", credits_empty_o, 1);
    chk("rst_full", credits_full_o, 0);
    reset_i = 1'b0;
    step();
    chk("idle_busy", busy_o, 0);
    chk("idle_empty", credits_empty_o, 1);
    cmd_ready_i = 1'b0; #1;
    chk("cmd_not_ready_busy", busy_o, 1);
    cmd_ready_i = 1'b1; req_ready_i = 1'b0; #1;
    chk("req_not_ready_busy", busy_o, 1);
    req_ready_i = 1'b1; #1;

    // Port 1 blocked cycles 0..3, accepted in cycle 4.
    mem_pkt_v_i = 3'b010;
    for (int c = 0; c < 4; c++) begin
      chk("p1_pre_timeout", timeout_o, 0);
      step();
    end
    chk("p1_timeout", timeout_o, 3'b010);
    chk("p1_busy", busy_o, 1);
    chk("p1_ho_c4", holdoff_o, 0);
    mem_pkt_yumi_i = 3'b010;
    step();
    mem_pkt_v_i = '0; mem_pkt_yumi_i = '0;
    chk("p1_ho_c5", holdoff_o, 1);
    chk("p1_to_c5", timeout_o, 0);
    step(); chk("p1_ho_c6", holdoff_o, 1);
    step(); chk("p1_ho_c7", holdoff_o, 1); chk("p1_busy_c7", busy_o, 1);
    step(); chk("p1_ho_c8", holdoff_o, 0); chk("p1_busy_c8", busy_o, 0);

    // Port 0: 3 blocked, 1 yumi, 3 blocked -> never times out.
    for (int c = 0; c < 7; c++) begin
      mem_pkt_v_i = 3'b001;
      mem_pkt_yumi_i = (c == 3) ? 3'b001 : 3'b000;
      step();
      chk("p0_no_timeout", timeout_o, 0);
      chk("p0_no_busy", busy_o, 0);
    end
    mem_pkt_v_i = '0; mem_pkt_yumi_i = '0;
    step();

    // Ports 0 and 2 blocked cycles 0..8, released in cycle 9.
    entries = 0; prev_ho = holdoff_o;
    mem_pkt_v_i = 3'b101;
    for (int c = 0; c < 11; c++) begin
      if (c == 4) chk("p02_timeout", timeout_o, 3'b101);
      if (c >= 5 && c <= 9) chk("p02_ho_held", holdoff_o, 1);
      if (c == 9) mem_pkt_v_i = '0;
      if (c == 10) begin
        chk("p02_ho_fall", holdoff_o, 0);
        chk("p02_to_clear", timeout_o, 0);
        chk("p02_busy", busy_o, 0);
      end
      if (holdoff_o && !prev_ho) entries++;
      prev_ho = holdoff_o;
      if (c < 10) step();
    end
    chk("p02_one_entry", entries, 1);

    // Credits: fill, simultaneous alloc+return, one return.
    credit_alloc_i = 1'b1;
    for (int c = 0; c < 32; c++) step();
    credit_alloc_i = 1'b0;
    chk("cr_count32", credit_count_o, 32);
    chk("cr_full", credits_full_o, 1);
    chk("cr_full_busy", busy_o, 1);
    credit_alloc_i = 1'b1; credit_return_i = 1'b1;
    step();
    credit_alloc_i = 1'b0; credit_return_i = 1'b0;
    chk("cr_both_hold", credit_count_o, 32);
    credit_return_i = 1'b1;
    step();
    credit_return_i = 1'b0;
    chk("cr_count31", credit_count_o, 31);
    chk("cr_not_full", credits_full_o, 0);
    chk("cr_busy_low", busy_o, 0);
    credit_return_i = 1'b1;
    for (int c = 0; c < 26; c++) step();
    credit_return_i = 1'b0;
    chk("cr_count5", credit_count_o, 5);

    // Enter HOLDOFF via port 2, then reset asynchronously mid-window.
    mem_pkt_v_i = 3'b100;
    for (int c = 0; c < 4; c++) step();
    mem_pkt_v_i = '0;
    step();
    chk("ar_in_holdoff", holdoff_o, 1);
    reset_i = 1'b1; #1;
    chk("ar_holdoff", holdoff_o, 0);
    chk("ar_count", credit_count_o, 0);
    chk("ar_empty", credits_empty_o, 1);
    chk("ar_busy", busy_o, 1);
    #1 reset_i = 1'b0;
    step();
    chk("ar_run", holdoff_o, 0);
    chk("ar_count_after", credit_count_o, 0);
    chk("ar_busy_after", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
